// File: rtl/dut_sram_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : dut_sram_host_if
//  Description : Signal bundle between the host/DUT side logic and the
//                dut_sram_host block.
//                The slave modport is the dut_sram_host view.
//                The master modport is the host + DUT side view.
//  Revision    : 1.0  initial release
// ============================================================================
interface dut_sram_host_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  // host control and host access port
  logic              host_start;
  logic              host_wr_en;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_rd_en;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_valid;
  logic              host_busy;
  logic              host_done;
  logic [15:0]       cycle_count;
  logic              timeout;
  // DUT control and DUT SRAM ports
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] sram_dut_read_addr;
  logic [DATA_W-1:0] dut_sram_read_data;
  logic              dut_sram_write_enable;
  logic [ADDR_W-1:0] dut_sram_write_addr;
  logic [DATA_W-1:0] dut_sram_write_data;

  modport slave (
    input  host_start, host_wr_en, host_wr_addr, host_wr_data,
    input  host_rd_en, host_rd_addr,
    input  dut_busy, sram_dut_read_addr,
    input  dut_sram_write_enable, dut_sram_write_addr, dut_sram_write_data,
    output host_rd_data, host_rd_valid, host_busy, host_done,
    output cycle_count, timeout, dut_run, dut_sram_read_data
  );

  modport master (
    output host_start, host_wr_en, host_wr_addr, host_wr_data,
    output host_rd_en, host_rd_addr,
    output dut_busy, sram_dut_read_addr,
    output dut_sram_write_enable, dut_sram_write_addr, dut_sram_write_data,
    input  host_rd_data, host_rd_valid, host_busy, host_done,
    input  cycle_count, timeout, dut_run, dut_sram_read_data
  );
endinterface
`default_nettype wire

// File: rtl/dut_sram_host.sv
`default_nettype none
// ============================================================================
//  Module      : dut_sram_host
//  Description : Host-side counterpart of the DUT SRAM interface. Owns the
//                input SRAM (host writes, DUT reads) and the output SRAM
//                (DUT writes, host reads), issues the dut_run pulse, tracks
//                dut_busy and reports done / cycle count / timeout.
//                Optional feature macro: DUT_WR_COUNT_EN adds o_dut_wr_count,
//                the number of in-range DUT writes accepted during a run.
//  Revision    : 1.0  initial release
// ============================================================================
module dut_sram_host #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int BUSY_WAIT   = 8,
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic               clk,
  input  logic               reset,
  dut_sram_host_if.slave     bus
`ifdef DUT_WR_COUNT_EN
  ,
  output logic [ADDR_W:0]    o_dut_wr_count
`endif
);

  localparam int                c_bw_w    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [c_bw_w-1:0] c_bw_last = c_bw_w'(BUSY_WAIT - 1);
  localparam logic [ADDR_W:0]   c_depth   = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]       c_timeout = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PULSE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_abort;
  logic                w_count_en;
  logic                w_start;
  logic [c_bw_w-1:0]   r_bw_cnt;
  logic [15:0]         r_cycle_count;
  logic                r_timeout;

  logic [DATA_W-1:0]   r_mem_in  [DEPTH];
  logic [DATA_W-1:0]   r_mem_out [DEPTH];
  logic [DATA_W-1:0]   r_dut_rd_data;
  logic [DATA_W-1:0]   r_host_rd_data;
  logic                r_host_rd_valid;

  logic                w_host_wr_ok;
  logic                w_dut_wr_ok;
  logic                w_dut_rd_ok;
  logic                w_host_rd_ok;

  // Address range qualifiers; anything at or above DEPTH is dropped / reads 0.
  assign w_host_wr_ok = (r_state == S_IDLE) && bus.host_wr_en &&
                        ({1'b0, bus.host_wr_addr} < c_depth);
  assign w_dut_wr_ok  = bus.dut_sram_write_enable &&
                        ({1'b0, bus.dut_sram_write_addr} < c_depth);
  assign w_dut_rd_ok  = {1'b0, bus.sram_dut_read_addr} < c_depth;
  assign w_host_rd_ok = {1'b0, bus.host_rd_addr} < c_depth;
  assign w_start      = (r_state == S_IDLE) && bus.host_start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; also flags which cycles are counted and which abort.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.host_start) w_state_nxt = S_PULSE;
      end
      S_PULSE: begin
        w_count_en  = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        w_count_en = 1'b1;
        if (bus.dut_busy) begin
          w_state_nxt = S_RUN;
        end else if (r_bw_cnt == c_bw_last) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end
      end
      S_RUN: begin
        // A normal finish wins over the limit; the abort cycle is not counted
        // so the reported count equals the limit.
        if (!bus.dut_busy) begin
          w_count_en  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cycle_count == c_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_count_en  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Busy-rise watchdog: counts WAIT_BUSY cycles since the pulse.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_PULSE) r_bw_cnt <= '0;
    else if (r_state == S_WAIT_BUSY)  r_bw_cnt <= r_bw_cnt + 1'b1;
  end

  // Run cycle counter and timeout flag, both cleared as the run starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
    end else if (w_start) begin
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_count_en && r_cycle_count != 16'hFFFF)
        r_cycle_count <= r_cycle_count + 16'd1;
      if (w_abort)
        r_timeout <= 1'b1;
    end
  end

  // SRAM array writes; arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_host_wr_ok) r_mem_in[bus.host_wr_addr]         <= bus.host_wr_data;
    if (w_dut_wr_ok)  r_mem_out[bus.dut_sram_write_addr] <= bus.dut_sram_write_data;
  end

  // Registered read ports; both read-first against same-cycle writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dut_rd_data   <= '0;
      r_host_rd_data  <= '0;
      r_host_rd_valid <= 1'b0;
    end else begin
      r_dut_rd_data   <= w_dut_rd_ok ? r_mem_in[bus.sram_dut_read_addr] : '0;
      r_host_rd_valid <= bus.host_rd_en;
      if (bus.host_rd_en)
        r_host_rd_data <= w_host_rd_ok ? r_mem_out[bus.host_rd_addr] : '0;
    end
  end

`ifdef DUT_WR_COUNT_EN
  logic [ADDR_W:0] r_wr_count;

  // Count of in-range DUT writes accepted while the run is active.
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_wr_count <= '0;
    end else if (w_dut_wr_ok && (r_state == S_WAIT_BUSY || r_state == S_RUN) &&
                 r_wr_count != '1) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign o_dut_wr_count = r_wr_count;
`endif

  assign bus.host_busy          = (r_state != S_IDLE);
  assign bus.host_done          = (r_state == S_DONE);
  assign bus.dut_run            = (r_state == S_PULSE);
  assign bus.cycle_count        = r_cycle_count;
  assign bus.timeout            = r_timeout;
  assign bus.dut_sram_read_data = r_dut_rd_data;
  assign bus.host_rd_data       = r_host_rd_data;
  assign bus.host_rd_valid      = r_host_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_dut_sram_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dut_sram_host
//  Description : Self-checking bench for dut_sram_host: vector table for the
//                input-SRAM path, queue-checked host reads of the output
//                SRAM, and hand-written run / timeout / reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dut_sram_host;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int DEPTH       = 4000;
  localparam int BUSY_WAIT   = 8;
  localparam int TIMEOUT_CYC = 100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dut_sram_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DUT_WR_COUNT_EN
  logic [ADDR_W:0] wr_count;
`endif

  dut_sram_host #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .BUSY_WAIT(BUSY_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DUT_WR_COUNT_EN
    ,
    .o_dut_wr_count (wr_count)
`endif
  );

  typedef struct {
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [11:0] rd_addr;
    logic [15:0] exp_rd;
    string       name;
  } vec_t;

  vec_t        vecs [10];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] out_model [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a host read for this cycle; expected word goes to the scoreboard.
  task automatic host_rd(input logic [11:0] a);
    bus.host_rd_en   = 1'b1;
    bus.host_rd_addr = a;
    exp_q.push_back(out_model.exists(int'(a)) ? out_model[int'(a)] : 16'h0000);
  endtask

  // Issue a DUT write for this cycle; call after any same-cycle host_rd.
  task automatic dut_wr(input logic [11:0] a, input logic [15:0] d);
    bus.dut_sram_write_enable = 1'b1;
    bus.dut_sram_write_addr   = a;
    bus.dut_sram_write_data   = d;
    if (int'(a) < DEPTH) out_model[int'(a)] = d;
  endtask

  task automatic clear_strobes();
    bus.host_start            = 1'b0;
    bus.host_wr_en            = 1'b0;
    bus.host_rd_en            = 1'b0;
    bus.dut_sram_write_enable = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (bus.host_done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Scoreboard: every valid host read word must match the oldest expectation.
  always @(negedge clk) begin : p_mon
    logic [15:0] e;
    if (!reset && bus.host_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL host_rd_spurious: actual=0x%0h required=no valid", bus.host_rd_data);
      end else begin
        e = exp_q.pop_front();
        check("host_rd_data", 32'(bus.host_rd_data), 32'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int seen;

    bus.host_start            = 1'b0;
    bus.host_wr_en            = 1'b0;
    bus.host_wr_addr          = '0;
    bus.host_wr_data          = '0;
    bus.host_rd_en            = 1'b0;
    bus.host_rd_addr          = '0;
    bus.dut_busy              = 1'b0;
    bus.sram_dut_read_addr    = 12'd4000;
    bus.dut_sram_write_enable = 1'b0;
    bus.dut_sram_write_addr   = '0;
    bus.dut_sram_write_data   = '0;

    vecs[0] = '{wr_en:1'b1, wr_addr:12'd0,    wr_data:16'hA5A5, rd_addr:12'd4000, exp_rd:16'h0000, name:"dut_rd_oob"};
    vecs[1] = '{wr_en:1'b1, wr_addr:12'd5,    wr_data:16'h1234, rd_addr:12'd0,    exp_rd:16'hA5A5, name:"dut_rd_addr0"};
    vecs[2] = '{wr_en:1'b0, wr_addr:12'd0,    wr_data:16'h0000, rd_addr:12'd5,    exp_rd:16'h1234, name:"dut_rd_addr5"};
    vecs[3] = '{wr_en:1'b1, wr_addr:12'd5,    wr_data:16'h5555, rd_addr:12'd5,    exp_rd:16'h1234, name:"dut_rd_same_cycle_old"};
    vecs[4] = '{wr_en:1'b0, wr_addr:12'd0,    wr_data:16'h0000, rd_addr:12'd5,    exp_rd:16'h5555, name:"dut_rd_after_overwrite"};
    vecs[5] = '{wr_en:1'b1, wr_addr:12'd4000, wr_data:16'h7777, rd_addr:12'd4095, exp_rd:16'h0000, name:"dut_rd_oob_max"};
    vecs[6] = '{wr_en:1'b1, wr_addr:12'd3999, wr_data:16'h0BAD, rd_addr:12'd0,    exp_rd:16'hA5A5, name:"dut_rd_keep0"};
    vecs[7] = '{wr_en:1'b0, wr_addr:12'd0,    wr_data:16'h0000, rd_addr:12'd3999, exp_rd:16'h0BAD, name:"dut_rd_last_word"};
    vecs[8] = '{wr_en:1'b1, wr_addr:12'd5,    wr_data:16'h1234, rd_addr:12'd5,    exp_rd:16'h5555, name:"dut_rd_restore_old"};
    vecs[9] = '{wr_en:1'b0, wr_addr:12'd0,    wr_data:16'h0000, rd_addr:12'd5,    exp_rd:16'h1234, name:"dut_rd_restored"};

    // Reset state, sampled while reset is still asserted.
    repeat (3) tick();
    check("rst_host_busy",   32'(bus.host_busy), 0);
    check("rst_host_done",   32'(bus.host_done), 0);
    check("rst_dut_run",     32'(bus.dut_run), 0);
    check("rst_cycle_count", 32'(bus.cycle_count), 0);
    check("rst_timeout",     32'(bus.timeout), 0);
    check("rst_rd_valid",    32'(bus.host_rd_valid), 0);
    check("rst_rd_data",     32'(bus.host_rd_data), 0);
    check("rst_dut_rd_data", 32'(bus.dut_sram_read_data), 0);
    reset = 1'b0;
    tick();

    // Input SRAM preload and DUT read port.
    for (int i = 0; i < 10; i++) begin
      bus.host_wr_en         = vecs[i].wr_en;
      bus.host_wr_addr       = vecs[i].wr_addr;
      bus.host_wr_data       = vecs[i].wr_data;
      bus.sram_dut_read_addr = vecs[i].rd_addr;
      tick();
      bus.host_wr_en = 1'b0;
      check(vecs[i].name, 32'(bus.dut_sram_read_data), 32'(vecs[i].exp_rd));
    end

    // Output SRAM seeded through the DUT port in IDLE, then read back.
    dut_wr(12'd7, 16'h1111);
    tick();
    clear_strobes();
    host_rd(12'd7);
    tick();
    clear_strobes();
    tick();
    check("host_rd_valid_low", 32'(bus.host_rd_valid), 0);
    check("host_rd_data_hold", 32'(bus.host_rd_data), 32'h1111);

    // Normal run: busy high for 20 cycles after the pulse.
    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    check("run_pulse", 32'(bus.dut_run), 1);
    check("run_busy",  32'(bus.host_busy), 1);
    tick();
    check("run_pulse_width", 32'(bus.dut_run), 0);
    bus.dut_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      clear_strobes();
      if (i == 5) begin
        host_rd(12'd7);
        dut_wr(12'd7, 16'hBEEF);
      end
      if (i == 6) host_rd(12'd7);
      if (i == 8) begin
        bus.host_wr_en   = 1'b1;
        bus.host_wr_addr = 12'd0;
        bus.host_wr_data = 16'h0000;
        bus.host_start   = 1'b1;
      end
    end
    clear_strobes();
    bus.dut_busy = 1'b0;
    wait_done(50, lat);
    check("run_done_latency", 32'(lat), 1);
    check("run_timeout",      32'(bus.timeout), 0);
    check("run_cycle_count",  32'(bus.cycle_count), 22);
`ifdef DUT_WR_COUNT_EN
    check("run_wr_count", 32'(wr_count), 1);
`endif
    tick();
    check("run_done_pulse_width", 32'(bus.host_done), 0);
    check("run_back_idle",        32'(bus.host_busy), 0);
    bus.sram_dut_read_addr = 12'd0;
    tick();
    check("busy_wr_blocked", 32'(bus.dut_sram_read_data), 32'hA5A5);

    // No-busy run: watchdog on busy rise.
    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    wait_done(30, lat);
    check("nobusy_done_latency", 32'(lat), BUSY_WAIT + 1);
    check("nobusy_timeout",      32'(bus.timeout), 1);
    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    check("done_start_ignored", 32'(bus.host_busy), 0);
    tick();

    // Hang run: busy never falls.
    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    bus.dut_busy   = 1'b1;
    wait_done(300, lat);
    check("hang_done_seen",   32'(lat > 0), 1);
    check("hang_timeout",     32'(bus.timeout), 1);
    check("hang_cycle_count", 32'(bus.cycle_count), TIMEOUT_CYC);
    bus.dut_busy = 1'b0;
    tick();

    // Restart clears timeout, then reset in the middle of the run.
    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    bus.dut_busy   = 1'b1;
    tick();
    check("restart_clears_timeout", 32'(bus.timeout), 0);
    repeat (10) tick();
    check("midrun_busy", 32'(bus.host_busy), 1);
    reset        = 1'b1;
    bus.dut_busy = 1'b0;
    tick();
    reset = 1'b0;
    check("midrst_idle",        32'(bus.host_busy), 0);
    check("midrst_cycle_count", 32'(bus.cycle_count), 0);
    check("midrst_dut_run",     32'(bus.dut_run), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.host_done || bus.dut_run) seen++;
    end
    check("midrst_no_done", 32'(seen), 0);
    check("midrst_mem0",    32'(bus.dut_sram_read_data), 32'hA5A5);
    bus.sram_dut_read_addr = 12'd5;
    tick();
    check("midrst_mem5",    32'(bus.dut_sram_read_data), 32'h1234);

    tick();
    check("rd_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
